// File: rtl/rvj1_mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: bus widths and the
// requester identifier that travels through the response-routing FIFO.
package rvj1_mem_arbiter_pkg;

    localparam int XLEN   = 32;
    localparam int NBYTES = XLEN / 8;

    // Requester identity: m0 is the instruction port, m1 the data port.
    typedef enum logic {
        ARB_M0 = 1'b0,
        ARB_M1 = 1'b1
    } arb_port_e;

    // Round-robin choice under contention: serve whoever was not served last.
    function automatic arb_port_e rr_pick(input arb_port_e last_served);
        return (last_served == ARB_M0) ? ARB_M1 : ARB_M0;
    endfunction

endpackage

// File: rtl/rvj1_mem_arbiter_id_fifo.sv
// In-order FIFO of requester IDs. One entry per request accepted by the
// memory and not yet answered; the head names the owner of the next response.
module rvj1_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] front_o
);

    // A one-deep FIFO still gets a one-bit pointer that simply never moves.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign front_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        // NOTE: state registers use non-blocking assignment so every flop samples
        // pre-edge values regardless of statement order.
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is deliberately not reset; entries are only read while
        // count_q says they hold valid data, so a reset would buy nothing.
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/rvj1_mem_arbiter.sv
// Two-requester arbiter sharing one valid-ready memory slave between the core's
// instruction port (m0) and data port (m1). Requests pass through a
// zero-latency mux; responses are steered back by an in-order ID FIFO.
module rvj1_mem_arbiter
    import rvj1_mem_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ROUND_ROBIN     = 1
) (
    input  logic              clk_i,
    input  logic              rstn_i,

    input  logic [XLEN-1:0]   m0_req_addr_i,
    input  logic [XLEN-1:0]   m0_req_data_i,
    input  logic [NBYTES-1:0] m0_req_strobe_i,
    input  logic              m0_req_write_i,
    input  logic              m0_req_valid_i,
    output logic              m0_req_ready_o,
    output logic [XLEN-1:0]   m0_rsp_data_o,
    output logic              m0_rsp_error_o,
    output logic              m0_rsp_valid_o,
    input  logic              m0_rsp_ready_i,

    input  logic [XLEN-1:0]   m1_req_addr_i,
    input  logic [XLEN-1:0]   m1_req_data_i,
    input  logic [NBYTES-1:0] m1_req_strobe_i,
    input  logic              m1_req_write_i,
    input  logic              m1_req_valid_i,
    output logic              m1_req_ready_o,
    output logic [XLEN-1:0]   m1_rsp_data_o,
    output logic              m1_rsp_error_o,
    output logic              m1_rsp_valid_o,
    input  logic              m1_rsp_ready_i,

    output logic [XLEN-1:0]   s_req_addr_o,
    output logic [XLEN-1:0]   s_req_data_o,
    output logic [NBYTES-1:0] s_req_strobe_o,
    output logic              s_req_write_o,
    output logic              s_req_valid_o,
    input  logic              s_req_ready_i,
    input  logic [XLEN-1:0]   s_rsp_data_i,
    input  logic              s_rsp_error_i,
    input  logic              s_rsp_valid_i,
    output logic              s_rsp_ready_o,

    output logic              err_unexp_rsp_o
);

    logic      fifo_full;
    logic      fifo_empty;
    logic      head_raw;
    arb_port_e head_id;

    logic      lock_q;
    arb_port_e lock_id_q;
    arb_port_e last_served_q;
    logic      err_q;

    logic      elig0;
    logic      elig1;
    logic      grant_valid;
    arb_port_e grant_id;
    logic      sel_m1;
    logic      req_hs;
    logic      rsp_pop;
    logic      rsp_unexp;

    // Full is taken from the registered count only, so a response pop never
    // combinationally reopens the request path.
    assign elig0 = m0_req_valid_i && !fifo_full;
    assign elig1 = m1_req_valid_i && !fifo_full;

    // Grant selection: a stalled request keeps its port until the handshake.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the if/else chain leaves a latch behind.
        grant_valid = 1'b0;
        grant_id    = ARB_M0;
        if (lock_q) begin
            grant_valid = 1'b1;
            grant_id    = lock_id_q;
        end else if (elig0 && elig1) begin
            grant_valid = 1'b1;
            grant_id    = (ROUND_ROBIN != 0) ? rr_pick(last_served_q) : ARB_M1;
        end else if (elig1) begin
            grant_valid = 1'b1;
            grant_id    = ARB_M1;
        end else if (elig0) begin
            grant_valid = 1'b1;
            grant_id    = ARB_M0;
        end
    end

    assign sel_m1 = (grant_id == ARB_M1);

    // Request mux toward memory; valid and ready are forced low during reset.
    assign s_req_valid_o  = rstn_i && grant_valid;
    assign s_req_addr_o   = sel_m1 ? m1_req_addr_i   : m0_req_addr_i;
    assign s_req_data_o   = sel_m1 ? m1_req_data_i   : m0_req_data_i;
    assign s_req_strobe_o = sel_m1 ? m1_req_strobe_i : m0_req_strobe_i;
    assign s_req_write_o  = sel_m1 ? m1_req_write_i  : m0_req_write_i;

    assign req_hs         = s_req_valid_o && s_req_ready_i;
    assign m0_req_ready_o = req_hs && !sel_m1;
    assign m1_req_ready_o = req_hs && sel_m1;

    // Response data and error are broadcast; only valid is steered.
    assign m0_rsp_data_o  = s_rsp_data_i;
    assign m1_rsp_data_o  = s_rsp_data_i;
    assign m0_rsp_error_o = s_rsp_error_i;
    assign m1_rsp_error_o = s_rsp_error_i;

    assign head_id = arb_port_e'(head_raw);

    // Response steering to the FIFO head; stray responses are swallowed.
    always_comb begin
        m0_rsp_valid_o = 1'b0;
        m1_rsp_valid_o = 1'b0;
        s_rsp_ready_o  = 1'b0;
        if (rstn_i) begin
            if (fifo_empty) begin
                s_rsp_ready_o = 1'b1;
            end else if (head_id == ARB_M1) begin
                m1_rsp_valid_o = s_rsp_valid_i;
                s_rsp_ready_o  = m1_rsp_ready_i;
            end else begin
                m0_rsp_valid_o = s_rsp_valid_i;
                s_rsp_ready_o  = m0_rsp_ready_i;
            end
        end
    end

    assign rsp_pop   = s_rsp_valid_i && s_rsp_ready_o && !fifo_empty;
    assign rsp_unexp = s_rsp_valid_i && fifo_empty;

    // Lock, fairness history and the sticky unexpected-response flag.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lock_q        <= 1'b0;
            lock_id_q     <= ARB_M0;
            last_served_q <= ARB_M1;
            err_q         <= 1'b0;
        end else begin
            if (req_hs) begin
                lock_q        <= 1'b0;
                last_served_q <= grant_id;
            end else if (s_req_valid_o) begin
                lock_q    <= 1'b1;
                lock_id_q <= grant_id;
            end
            if (rsp_unexp) err_q <= 1'b1;
        end
    end

    assign err_unexp_rsp_o = err_q;

    rvj1_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1)
    ) u_id_fifo (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .push_i      (req_hs),
        .push_data_i (grant_id),
        .pop_i       (rsp_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .front_o     (head_raw)
    );

endmodule

// File: tb/tb_rvj1_mem_arbiter.sv
// Directed bench for rvj1_mem_arbiter: a vector table for the cycle-by-cycle
// grant/FIFO behaviour, then hand-written sequences against a small SRAM model.
module tb_rvj1_mem_arbiter;
    import rvj1_mem_arbiter_pkg::*;

    localparam logic [31:0] A0 = 32'h8000_0000;
    localparam logic [31:0] A1 = 32'h0000_1000;

    logic        clk;
    logic        rstn;
    logic [31:0] m0_req_addr, m0_req_data, m1_req_addr, m1_req_data;
    logic [3:0]  m0_req_strobe, m1_req_strobe;
    logic        m0_req_write, m0_req_valid, m1_req_write, m1_req_valid;
    logic        m0_req_ready, m1_req_ready;
    logic [31:0] m0_rsp_data, m1_rsp_data;
    logic        m0_rsp_error, m1_rsp_error, m0_rsp_valid, m1_rsp_valid;
    logic        m0_rsp_ready, m1_rsp_ready;
    logic [31:0] s_req_addr, s_req_data;
    logic [3:0]  s_req_strobe;
    logic        s_req_write, s_req_valid, s_req_ready;
    logic [31:0] s_rsp_data;
    logic        s_rsp_error, s_rsp_valid, s_rsp_ready;
    logic        err_unexp;

    // Outputs of the fixed-priority instance (shares all inputs).
    logic        fp_m0_req_ready, fp_m1_req_ready;
    logic [31:0] fp_m0_rsp_data, fp_m1_rsp_data;
    logic        fp_m0_rsp_error, fp_m1_rsp_error, fp_m0_rsp_valid, fp_m1_rsp_valid;
    logic [31:0] fp_s_req_addr, fp_s_req_data;
    logic [3:0]  fp_s_req_strobe;
    logic        fp_s_req_write, fp_s_req_valid, fp_s_rsp_ready, fp_err_unexp;

    int n_pass  = 0;
    int n_total = 0;

    rvj1_mem_arbiter #(.MAX_OUTSTANDING(2), .ROUND_ROBIN(1)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .m0_req_addr_i(m0_req_addr), .m0_req_data_i(m0_req_data), .m0_req_strobe_i(m0_req_strobe),
        .m0_req_write_i(m0_req_write), .m0_req_valid_i(m0_req_valid), .m0_req_ready_o(m0_req_ready),
        .m0_rsp_data_o(m0_rsp_data), .m0_rsp_error_o(m0_rsp_error), .m0_rsp_valid_o(m0_rsp_valid),
        .m0_rsp_ready_i(m0_rsp_ready),
        .m1_req_addr_i(m1_req_addr), .m1_req_data_i(m1_req_data), .m1_req_strobe_i(m1_req_strobe),
        .m1_req_write_i(m1_req_write), .m1_req_valid_i(m1_req_valid), .m1_req_ready_o(m1_req_ready),
        .m1_rsp_data_o(m1_rsp_data), .m1_rsp_error_o(m1_rsp_error), .m1_rsp_valid_o(m1_rsp_valid),
        .m1_rsp_ready_i(m1_rsp_ready),
        .s_req_addr_o(s_req_addr), .s_req_data_o(s_req_data), .s_req_strobe_o(s_req_strobe),
        .s_req_write_o(s_req_write), .s_req_valid_o(s_req_valid), .s_req_ready_i(s_req_ready),
        .s_rsp_data_i(s_rsp_data), .s_rsp_error_i(s_rsp_error), .s_rsp_valid_i(s_rsp_valid),
        .s_rsp_ready_o(s_rsp_ready), .err_unexp_rsp_o(err_unexp)
    );

    rvj1_mem_arbiter #(.MAX_OUTSTANDING(2), .ROUND_ROBIN(0)) dut_fp (
        .clk_i(clk), .rstn_i(rstn),
        .m0_req_addr_i(m0_req_addr), .m0_req_data_i(m0_req_data), .m0_req_strobe_i(m0_req_strobe),
        .m0_req_write_i(m0_req_write), .m0_req_valid_i(m0_req_valid), .m0_req_ready_o(fp_m0_req_ready),
        .m0_rsp_data_o(fp_m0_rsp_data), .m0_rsp_error_o(fp_m0_rsp_error), .m0_rsp_valid_o(fp_m0_rsp_valid),
        .m0_rsp_ready_i(m0_rsp_ready),
        .m1_req_addr_i(m1_req_addr), .m1_req_data_i(m1_req_data), .m1_req_strobe_i(m1_req_strobe),
        .m1_req_write_i(m1_req_write), .m1_req_valid_i(m1_req_valid), .m1_req_ready_o(fp_m1_req_ready),
        .m1_rsp_data_o(fp_m1_rsp_data), .m1_rsp_error_o(fp_m1_rsp_error), .m1_rsp_valid_o(fp_m1_rsp_valid),
        .m1_rsp_ready_i(m1_rsp_ready),
        .s_req_addr_o(fp_s_req_addr), .s_req_data_o(fp_s_req_data), .s_req_strobe_o(fp_s_req_strobe),
        .s_req_write_o(fp_s_req_write), .s_req_valid_o(fp_s_req_valid), .s_req_ready_i(s_req_ready),
        .s_rsp_data_i(s_rsp_data), .s_rsp_error_i(s_rsp_error), .s_rsp_valid_i(s_rsp_valid),
        .s_rsp_ready_o(fp_s_rsp_ready), .err_unexp_rsp_o(fp_err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic clear_inputs();
        m0_req_addr = A0; m0_req_data = '0; m0_req_strobe = 4'hF; m0_req_write = 1'b0; m0_req_valid = 1'b0;
        m1_req_addr = A1; m1_req_data = '0; m1_req_strobe = 4'hF; m1_req_write = 1'b0; m1_req_valid = 1'b0;
        m0_rsp_ready = 1'b0; m1_rsp_ready = 1'b0;
        s_req_ready = 1'b0; s_rsp_data = '0; s_rsp_error = 1'b0; s_rsp_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // ---------------- SRAM model (two-entry response queue) ----------------
    logic [31:0] mem_q [16];
    logic [31:0] rspq [$];

    task automatic mem_drive();
        s_rsp_valid = (rspq.size() > 0);
        s_rsp_data  = (rspq.size() > 0) ? rspq[0] : 32'h0;
        s_req_ready = (rspq.size() < 2);
    endtask

    task automatic mem_update(input bit hs, input bit pop, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] strb, input logic wr);
        logic [3:0] idx;
        if (pop) void'(rspq.pop_front());
        if (hs) begin
            idx = addr[5:2];
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) mem_q[idx][8*b +: 8] = data[8*b +: 8];
                rspq.push_back(32'h0);
            end else begin
                rspq.push_back(mem_q[idx]);
            end
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        wr;
    } req_t;

    req_t        r0 [$];
    req_t        r1 [$];
    logic [31:0] got0 [$];
    logic [31:0] got1 [$];

    // Both requesters issue their queued requests and always accept responses.
    task automatic run_traffic(input int max_cycles, input int n_exp0, input int n_exp1);
        int          cyc;
        bit          hs, pop, acc0, acc1, dual;
        logic [31:0] a, d;
        logic [3:0]  s;
        logic        w;
        cyc  = 0;
        dual = 1'b0;
        while ((got0.size() < n_exp0 || got1.size() < n_exp1) && cyc < max_cycles) begin
            m0_req_valid = (r0.size() > 0);
            if (r0.size() > 0) begin
                m0_req_addr = r0[0].addr; m0_req_data = r0[0].data;
                m0_req_strobe = r0[0].strb; m0_req_write = r0[0].wr;
            end
            m1_req_valid = (r1.size() > 0);
            if (r1.size() > 0) begin
                m1_req_addr = r1[0].addr; m1_req_data = r1[0].data;
                m1_req_strobe = r1[0].strb; m1_req_write = r1[0].wr;
            end
            m0_rsp_ready = 1'b1;
            m1_rsp_ready = 1'b1;
            mem_drive();
            #1;
            hs   = s_req_valid && s_req_ready;
            pop  = s_rsp_valid && s_rsp_ready;
            acc0 = m0_req_ready;
            acc1 = m1_req_ready;
            a = s_req_addr; d = s_req_data; s = s_req_strobe; w = s_req_write;
            if (m0_rsp_valid) got0.push_back(m0_rsp_data);
            if (m1_rsp_valid) got1.push_back(m1_rsp_data);
            if (m0_rsp_valid && m1_rsp_valid) dual = 1'b1;
            @(posedge clk);
            @(negedge clk);
            mem_update(hs, pop, a, d, s, w);
            if (acc0) void'(r0.pop_front());
            if (acc1) void'(r1.pop_front());
            cyc++;
        end
        check("traffic_completed_in_budget", 32'(cyc < max_cycles), 32'd1);
        check("traffic_no_dual_rsp_valid", 32'(dual), 32'd0);
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
    endtask

    // ---------------- vector table ----------------
    // in : {m0_valid, m1_valid, s_req_ready, s_rsp_valid, m0_rsp_ready, m1_rsp_ready}
    // exp: {s_req_valid, m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, s_rsp_ready}
    typedef struct {
        string       name;
        logic [5:0]  in_bits;
        logic [5:0]  exp_bits;
        logic [31:0] e_addr;
        logic        e_err;
    } vec_t;

    vec_t vecs [16];

    initial begin
        vecs[0]  = '{"idle",         6'b001000, 6'b000000, A0, 1'b0};
        vecs[1]  = '{"both_rr_m0",   6'b111000, 6'b110000, A0, 1'b0};
        vecs[2]  = '{"m1_push_pop",  6'b011110, 6'b101101, A1, 1'b0};
        vecs[3]  = '{"lock_set",     6'b110000, 6'b100000, A0, 1'b0};
        vecs[4]  = '{"lock_hold",    6'b110000, 6'b100000, A0, 1'b0};
        vecs[5]  = '{"lock_rel",     6'b111100, 6'b110010, A0, 1'b0};
        vecs[6]  = '{"full_blocks",  6'b111101, 6'b000011, A0, 1'b0};
        vecs[7]  = '{"m1_fill",      6'b011100, 6'b101100, A1, 1'b0};
        vecs[8]  = '{"full_m0",      6'b101110, 6'b000101, A0, 1'b0};
        vecs[9]  = '{"push_pop",     6'b101101, 6'b110011, A0, 1'b0};
        vecs[10] = '{"rr_m1",        6'b111110, 6'b101101, A1, 1'b0};
        vecs[11] = '{"drain",        6'b001101, 6'b000011, A0, 1'b0};
        vecs[12] = '{"unexp",        6'b001111, 6'b000001, A0, 1'b0};
        vecs[13] = '{"err_sticky",   6'b001000, 6'b000000, A0, 1'b1};
        vecs[14] = '{"err_hold_req", 6'b101000, 6'b110000, A0, 1'b1};
        vecs[15] = '{"final_rsp",    6'b001110, 6'b000101, A0, 1'b1};

        // Reset state: requests and responses offered during reset must not leak.
        rstn = 1'b0;
        clear_inputs();
        m0_req_valid = 1'b1; m1_req_valid = 1'b1; s_req_ready = 1'b1;
        s_rsp_valid = 1'b1; m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
        #2;
        check("rst.s_req_valid", 32'(s_req_valid), 32'd0);
        check("rst.m0_req_ready", 32'(m0_req_ready), 32'd0);
        check("rst.m1_req_ready", 32'(m1_req_ready), 32'd0);
        check("rst.m0_rsp_valid", 32'(m0_rsp_valid), 32'd0);
        check("rst.m1_rsp_valid", 32'(m1_rsp_valid), 32'd0);
        check("rst.s_rsp_ready", 32'(s_rsp_ready), 32'd0);
        check("rst.err", 32'(err_unexp), 32'd0);
        clear_inputs();
        @(negedge clk);
        rstn = 1'b1;

        // Table-driven cycle sequence.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            m0_req_addr  = A0; m0_req_write = 1'b0;
            m1_req_addr  = A1; m1_req_write = 1'b1;
            s_rsp_data   = 32'h13;
            m0_req_valid = vecs[i].in_bits[5];
            m1_req_valid = vecs[i].in_bits[4];
            s_req_ready  = vecs[i].in_bits[3];
            s_rsp_valid  = vecs[i].in_bits[2];
            m0_rsp_ready = vecs[i].in_bits[1];
            m1_rsp_ready = vecs[i].in_bits[0];
            #1;
            check({vecs[i].name, ".s_req_valid"}, 32'(s_req_valid), 32'(vecs[i].exp_bits[5]));
            check({vecs[i].name, ".m0_req_ready"}, 32'(m0_req_ready), 32'(vecs[i].exp_bits[4]));
            check({vecs[i].name, ".m1_req_ready"}, 32'(m1_req_ready), 32'(vecs[i].exp_bits[3]));
            check({vecs[i].name, ".m0_rsp_valid"}, 32'(m0_rsp_valid), 32'(vecs[i].exp_bits[2]));
            check({vecs[i].name, ".m1_rsp_valid"}, 32'(m1_rsp_valid), 32'(vecs[i].exp_bits[1]));
            check({vecs[i].name, ".err"}, 32'(err_unexp), 32'(vecs[i].e_err));
            if (vecs[i].exp_bits[5])
                check({vecs[i].name, ".s_req_addr"}, s_req_addr, vecs[i].e_addr);
            if (vecs[i].in_bits[2])
                check({vecs[i].name, ".s_rsp_ready"}, 32'(s_rsp_ready), 32'(vecs[i].exp_bits[0]));
        end

        // Contention straight after reset: round-robin vs fixed priority.
        do_reset();
        check("rr.err_cleared", 32'(err_unexp), 32'd0);
        m0_req_valid = 1'b1; m1_req_valid = 1'b1; s_req_ready = 1'b1;
        #1;
        check("rr.first_addr", s_req_addr, A0);
        check("rr.first_m0_ready", 32'(m0_req_ready), 32'd1);
        check("fp.first_addr", fp_s_req_addr, A1);
        check("fp.first_m1_ready", 32'(fp_m1_req_ready), 32'd1);
        check("fp.first_m0_ready", 32'(fp_m0_req_ready), 32'd0);
        @(negedge clk);
        #1;
        check("rr.second_addr", s_req_addr, A1);
        check("rr.second_m1_ready", 32'(m1_req_ready), 32'd1);
        check("fp.second_addr", fp_s_req_addr, A1);
        check("fp.second_valid", 32'(fp_s_req_valid), 32'd1);

        // Stall with m0 granted while m1 arrives; last_served is m0 so only
        // the lock keeps m1 from taking over.
        do_reset();
        m0_req_valid = 1'b1; s_req_ready = 1'b1;
        #1;
        check("lock.pre_m0_ready", 32'(m0_req_ready), 32'd1);
        @(negedge clk);
        m0_req_addr = 32'h8000_0008; s_req_ready = 1'b0;
        s_rsp_valid = 1'b1; m0_rsp_ready = 1'b1;
        #1;
        check("lock.c1_addr", s_req_addr, 32'h8000_0008);
        check("lock.c1_m0_rsp_valid", 32'(m0_rsp_valid), 32'd1);
        @(negedge clk);
        s_rsp_valid = 1'b0; m1_req_valid = 1'b1;
        m1_req_write = 1'b1; m1_req_data = 32'hCAFE_F00D; m1_req_strobe = 4'b0101;
        #1;
        check("lock.c2_addr", s_req_addr, 32'h8000_0008);
        check("lock.c2_m1_ready", 32'(m1_req_ready), 32'd0);
        @(negedge clk);
        #1;
        check("lock.c3_addr", s_req_addr, 32'h8000_0008);
        check("lock.c3_valid", 32'(s_req_valid), 32'd1);
        @(negedge clk);
        s_req_ready = 1'b1;
        #1;
        check("lock.hs_m0_ready", 32'(m0_req_ready), 32'd1);
        check("lock.hs_m1_ready", 32'(m1_req_ready), 32'd0);
        @(negedge clk);
        m0_req_valid = 1'b0;
        #1;
        check("lock.m1_addr", s_req_addr, A1);
        check("lock.m1_ready", 32'(m1_req_ready), 32'd1);
        check("lock.m1_data", s_req_data, 32'hCAFE_F00D);
        check("lock.m1_strobe", 32'(s_req_strobe), 32'h5);
        check("lock.m1_write", 32'(s_req_write), 32'd1);

        // FIFO now holds {m0, m1}; reset in the middle of a response.
        @(negedge clk);
        m1_req_valid = 1'b0; s_req_ready = 1'b1;
        s_rsp_valid = 1'b1; s_rsp_error = 1'b1; s_rsp_data = 32'h0BAD_0001;
        m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
        #1;
        check("midrst.m0_rsp_valid", 32'(m0_rsp_valid), 32'd1);
        check("midrst.m0_rsp_error", 32'(m0_rsp_error), 32'd1);
        check("midrst.m1_rsp_error", 32'(m1_rsp_error), 32'd1);
        check("midrst.m1_rsp_data", m1_rsp_data, 32'h0BAD_0001);
        m0_req_valid = 1'b1;
        #1;
        rstn = 1'b0;
        #1;
        check("midrst.in_rst_s_req_valid", 32'(s_req_valid), 32'd0);
        check("midrst.in_rst_m0_rsp_valid", 32'(m0_rsp_valid), 32'd0);
        check("midrst.in_rst_s_rsp_ready", 32'(s_rsp_ready), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        s_rsp_error = 1'b0;
        #1;
        check("midrst.after_m0_rsp_valid", 32'(m0_rsp_valid), 32'd0);
        check("midrst.after_m1_rsp_valid", 32'(m1_rsp_valid), 32'd0);
        check("midrst.after_drop_ready", 32'(s_rsp_ready), 32'd1);
        check("midrst.after_req_valid", 32'(s_req_valid), 32'd1);

        // SRAM-backed traffic: a single m0 read, then interleaved write/read.
        do_reset();
        mem_q[0] = 32'h0000_0013;
        mem_q[1] = 32'h1234_5678;
        rspq.delete();
        m0_req_addr = A0; m0_req_valid = 1'b1; m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
        mem_drive();
        #1;
        check("single.m0_req_ready", 32'(m0_req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        mem_update(1'b1, 1'b0, A0, 32'h0, 4'h0, 1'b0);
        m0_req_valid = 1'b0;
        mem_drive();
        #1;
        check("single.m0_rsp_valid", 32'(m0_rsp_valid), 32'd1);
        check("single.m0_rsp_data", m0_rsp_data, 32'h0000_0013);
        check("single.m1_rsp_valid", 32'(m1_rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        mem_update(1'b0, 1'b1, A0, 32'h0, 4'h0, 1'b0);
        mem_drive();
        #1;
        check("single.m0_rsp_done", 32'(m0_rsp_valid), 32'd0);
        check("single.m1_rsp_idle", 32'(m1_rsp_valid), 32'd0);
        @(negedge clk);

        // last_served is m0 here, so the m1 write wins first; m0's read then
        // observes the merged word, as does m1's follow-up read.
        r0.delete(); r1.delete(); got0.delete(); got1.delete();
        r0.push_back('{32'h8000_0004, 32'h0, 4'b0000, 1'b0});
        r1.push_back('{32'h8000_0004, 32'hDEAD_BEEF, 4'b0011, 1'b1});
        r1.push_back('{32'h8000_0004, 32'h0, 4'b0000, 1'b0});
        run_traffic(40, 1, 2);
        check("inter.m0_rsp_count", 32'(got0.size()), 32'd1);
        check("inter.m1_rsp_count", 32'(got1.size()), 32'd2);
        check("inter.m0_read", (got0.size() > 0) ? got0[0] : 32'hXXXX_XXXX, 32'h1234_BEEF);
        check("inter.m1_read", (got1.size() > 1) ? got1[1] : 32'hXXXX_XXXX, 32'h1234_BEEF);
        check("inter.err", 32'(err_unexp), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
